intr_req_cond: RTL and testbench
================================

# intr_req_cond

Interrupt request conditioner that sits directly upstream of the 8-source interrupt controller and drives its `intr_rq[7:0]` input. It synchronises eight asynchronous peripheral interrupt lines, detects level or rising-edge events per line, latches them as pending, and applies a mask. It also snoops the controller/processor bus and drops a pending request when the processor signals end-of-interrupt (EOI) for that source.

## Interface
- `SYNC_STAGES`, 2, synchroniser depth per line (legal values: 2 or more)
- `EOI_PREFIX`, 5'b10100, value of bus bits [7:3] that marks an EOI word
- `clk_in`  in  1  clock; all logic is on the rising edge
- `rst_in`  in  1  reset, synchronous, active-low
- `irq_raw`  in  8  asynchronous peripheral interrupt lines, active-high
- `cfg_we`  in  1  configuration write strobe, active-high, one cycle
- `cfg_addr`  in  1  register select: 0 = mask, 1 = edge_mode
- `cfg_data`  in  8  configuration write data
- `eoi_bus`  in  8  snoop of the controller data bus
- `eoi_strb_n`  in  1  snoop of the processor strobe (`intr_in`), active-low
- `bus_oe_snoop`  in  1  snoop of the controller `bus_oe`; 1 = controller drives the bus
- `intr_rq`  out  8  requests to the controller: `pending & ~mask`
- `pend_o`  out  8  raw pending status, unmasked
- `ovf_o`  out  8  sticky per-line overflow flags

## Operation
- **Synchroniser**
  - Each `irq_raw[i]` passes through `SYNC_STAGES` flops, giving `s[i]`.
  - A further flop holds `prev[i]`.
  - All of these reset to 0.
- **Set condition** (`set[i]`)
  - When `edge_mode[i]=0` (level mode): `s[i]`.
  - When `edge_mode[i]=1` (edge mode): `s[i] & ~prev[i]`.
- **EOI detect** (`eoi_hit`)
  - `eoi_hit = ~eoi_strb_n & ~bus_oe_snoop & (eoi_bus[7:3]==EOI_PREFIX)`.
  - Target line is `id = eoi_bus[2:0]`.
  - An EOI word driven while `bus_oe_snoop=1` is ignored. This covers the controller's own `{5'b01011,id}` vector and any other controller-driven value.
- **Pending register** update on each edge:
  - `pending[i] <= set[i] | (pending[i] & ~(eoi_hit & id==i))`.
  - When `set` and EOI for the same line land in the same cycle, set wins and `pending` stays 1, so no event is lost.
  - In level mode, a line still asserted after EOI is therefore re-pended immediately.
- **Overflow** (edge mode only)
  - `ovf[i]` is set when `set[i]` occurs while `pending[i]=1` and no EOI for `i` arrives in that cycle.
  - `ovf[i]` is cleared by an EOI for `i`.
  - If a new edge and an EOI for `i` land in the same cycle, `ovf[i]` ends at 0.
- **Configuration registers**
  - A write with `cfg_we=1` updates the register selected by `cfg_addr` on the same edge.
  - The new value affects `set` and `intr_rq` from the next cycle.
  - Masking a line does not clear its `pending` bit; unmasking a pending line re-presents it on `intr_rq`.
  - Changing `edge_mode` does not clear `pending` or `ovf`.
- **Reset**
  - Clears `pending`, `ovf`, `mask` (to 8'h00) and `edge_mode` (to 8'h00, all level).
  - Clears all synchroniser flops and `prev`.
  - Reset values of outputs: `intr_rq`, `pend_o` and `ovf_o` are all 8'h00.
  - Reset mid-operation discards all pending events.
  - An edge-mode line held high across reset release is seen as one rising edge once it crosses the synchroniser.

## Timing
- `intr_rq` and `pend_o` depend only on registered values: `pending` and `mask`, with no input-to-output combinational path.
- **Raw to request latency:**
  - `irq_raw` rise set up before edge N gives `intr_rq` high after edge N+`SYNC_STAGES`.
  - With the default depth this is 3 edges.
- **EOI to drop:** an EOI sampled at edge N drops `intr_rq[id]` after edge N, provided no new `set` occurs.
- **Minimum detectable pulse:** `irq_raw` pulses shorter than one `clk_in` period may be missed in either mode.

## Configuration
- Macro `INTR_COND_OVF_EN`.
  - **Defined:** overflow tracking is implemented as described above.
  - **Undefined:** the `ovf` register is not built and `ovf_o` is tied to 8'h00; all other behaviour is unchanged.

## Test plan
1. **Reset:** hold `rst_in=0` for 3 cycles with `irq_raw=8'hFF` -> `intr_rq`, `pend_o` and `ovf_o` are 8'h00 throughout.
2. **Level request and EOI:**
   - Stimulus: `irq_raw=8'b1010_1010`, then EOI `eoi_bus=8'b1010_0011` with `eoi_strb_n=0` and `bus_oe_snoop=0` for one cycle.
   - Required: `intr_rq=8'hAA` 3 edges after the `irq_raw` change.
   - Required: after the EOI, `pend_o[3]` stays 1 while `irq_raw[3]` is held.
   - Deassert `irq_raw[3]` and repeat the EOI -> `intr_rq=8'hA2`.
3. **Edge mode and overflow:**
   - Stimulus: write `edge_mode=8'h01`, then pulse `irq_raw[0]` twice, 2 cycles wide each, before any EOI.
   - Required: `intr_rq[0]=1` and `ovf_o[0]=1`.
   - A subsequent EOI `8'b1010_0000` clears both bits.
4. **Mask:** with `pending=8'h55`, write `mask=8'h0F` -> `intr_rq=8'h50` and `pend_o=8'h55`; write `mask=8'h00` -> `intr_rq=8'h55`.
5. **EOI filtering:**
   - `eoi_bus=8'b0101_1010`, `eoi_strb_n=0`, `bus_oe_snoop=1` -> `pending` unchanged.
   - `eoi_bus=8'b1010_0010` with `eoi_strb_n=1` -> `pending` unchanged.
6. **Simultaneous event:** a new edge on line 2 and EOI `8'b1010_0010` in the same cycle -> `pend_o[2]=1` and `ovf_o[2]=0`.

Source files
------------

// File: rtl/intr_req_cond.sv
// Interrupt request conditioner: synchronises eight peripheral lines, latches level/edge events as pending,
// masks them toward the controller and drops them on snooped EOI. Optional overflow tracking: INTR_COND_OVF_EN.
module intr_req_cond #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [4:0] EOI_PREFIX  = 5'b10100
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] irq_raw,
   input  logic       cfg_we,
   input  logic       cfg_addr,
   input  logic [7:0] cfg_data,
   input  logic [7:0] eoi_bus,
   input  logic       eoi_strb_n,
   input  logic       bus_oe_snoop,
   output logic [7:0] intr_rq,
   output logic [7:0] pend_o,
   output logic [7:0] ovf_o
);

   logic [7:0] sync_r [SYNC_STAGES];
   logic [7:0] prev_r;
   logic [7:0] pending_r;
   logic [7:0] mask_r;
   logic [7:0] edge_mode_r;

   logic [7:0] sync_s;
   logic [7:0] set_s;
   logic       eoi_hit_s;
   logic [7:0] eoi_vec_s;

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Event detection and EOI decode; controller-driven bus words never count as EOI
   always_comb begin
      set_s     = (~edge_mode_r & sync_s) | (edge_mode_r & sync_s & ~prev_r);
      eoi_hit_s = ~eoi_strb_n & ~bus_oe_snoop & (eoi_bus[7:3] == EOI_PREFIX);
      if (eoi_hit_s) begin
         eoi_vec_s = 8'h01 << eoi_bus[2:0];
      end else begin
         eoi_vec_s = 8'h00;
      end
   end

   // Synchroniser chain and previous-sample flop
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_r[k] <= 8'h00;
         end
         prev_r <= 8'h00;
      end else begin
         sync_r[0] <= irq_raw;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_r[k] <= sync_r[k-1];
         end
         prev_r <= sync_s;
      end
   end

   // Pending latch: a new set beats a same-cycle EOI so no event is lost
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         pending_r <= 8'h00;
      end else begin
         pending_r <= set_s | (pending_r & ~eoi_vec_s);
      end
   end

   // Configuration registers
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         mask_r      <= 8'h00;
         edge_mode_r <= 8'h00;
      end else if (cfg_we) begin
         case (cfg_addr)
            1'b0:    mask_r      <= cfg_data;
            1'b1:    edge_mode_r <= cfg_data;
            default: mask_r      <= mask_r;
         endcase
      end else begin
         mask_r      <= mask_r;
         edge_mode_r <= edge_mode_r;
      end
   end

`ifdef INTR_COND_OVF_EN
   logic [7:0] ovf_r;

   // Sticky overflow: edge-mode event on an already pending line without a same-cycle EOI
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         ovf_r <= 8'h00;
      end else begin
         ovf_r <= (ovf_r | (edge_mode_r & set_s & pending_r)) & ~eoi_vec_s;
      end
   end

   assign ovf_o = ovf_r;
`else
   assign ovf_o = 8'h00;
`endif

   assign intr_rq = pending_r & ~mask_r;
   assign pend_o  = pending_r;

endmodule

// File: tb/tb_intr_req_cond.sv
// Directed bench for intr_req_cond: expectations are queued when stimulus is applied and checked on output.
module tb_intr_req_cond;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic [7:0] irq_raw;
   logic       cfg_we;
   logic       cfg_addr;
   logic [7:0] cfg_data;
   logic [7:0] eoi_bus;
   logic       eoi_strb_n;
   logic       bus_oe_snoop;
   logic [7:0] intr_rq;
   logic [7:0] pend_o;
   logic [7:0] ovf_o;

`ifdef INTR_COND_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   typedef struct {
      string      tag;
      logic [7:0] rq;
      logic [7:0] pend;
      logic [7:0] ovf;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   intr_req_cond dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .irq_raw      (irq_raw),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .eoi_bus      (eoi_bus),
      .eoi_strb_n   (eoi_strb_n),
      .bus_oe_snoop (bus_oe_snoop),
      .intr_rq      (intr_rq),
      .pend_o       (pend_o),
      .ovf_o        (ovf_o)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic [7:0] rq, input logic [7:0] pend, input logic [7:0] ovf);
      exp_t e;
      e.tag  = tag;
      e.rq   = rq;
      e.pend = pend;
      e.ovf  = ovf;
      sb_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      vectors++;
      if (sb_q.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty: got no expectation, required one");
      end else begin
         e = sb_q.pop_front();
         assert ({intr_rq, pend_o, ovf_o} === {e.rq, e.pend, e.ovf}) else begin
            miscompares++;
            $error("FAIL %s: got rq=%h pend=%h ovf=%h, required rq=%h pend=%h ovf=%h",
                   e.tag, intr_rq, pend_o, ovf_o, e.rq, e.pend, e.ovf);
         end
      end
   endtask

   task automatic eoi(input logic [7:0] word, input logic strb_n, input logic oe);
      eoi_bus      = word;
      eoi_strb_n   = strb_n;
      bus_oe_snoop = oe;
      step();
      eoi_bus      = 8'h00;
      eoi_strb_n   = 1'b1;
      bus_oe_snoop = 1'b0;
   endtask

   task automatic cfg_write(input logic addr, input logic [7:0] data);
      cfg_we   = 1'b1;
      cfg_addr = addr;
      cfg_data = data;
      step();
      cfg_we   = 1'b0;
      cfg_addr = 1'b0;
      cfg_data = 8'h00;
   endtask

   initial begin
      rst_in       = 1'b0;
      irq_raw      = 8'hFF;
      cfg_we       = 1'b0;
      cfg_addr     = 1'b0;
      cfg_data     = 8'h00;
      eoi_bus      = 8'h00;
      eoi_strb_n   = 1'b1;
      bus_oe_snoop = 1'b0;

      // reset held with all lines high
      for (int i = 0; i < 3; i++) begin
         step();
         push_exp("reset", 8'h00, 8'h00, 8'h00);
         check_out();
      end
      rst_in  = 1'b1;
      irq_raw = 8'h00;
      step(); step(); step();
      push_exp("idle_after_reset", 8'h00, 8'h00, 8'h00);
      check_out();

      // level request: visible after the third edge, not the second
      irq_raw = 8'hAA;
      push_exp("level_latency_early", 8'h00, 8'h00, 8'h00);
      push_exp("level_request", 8'hAA, 8'hAA, 8'h00);
      step(); step();
      check_out();
      step();
      check_out();

      push_exp("level_eoi_still_held", 8'hAA, 8'hAA, 8'h00);
      eoi(8'b1010_0011, 1'b0, 1'b0);
      check_out();

      irq_raw = 8'hA2;
      push_exp("line3_released_no_eoi", 8'hAA, 8'hAA, 8'h00);
      step(); step(); step();
      check_out();
      push_exp("line3_eoi_drop", 8'hA2, 8'hA2, 8'h00);
      eoi(8'b1010_0011, 1'b0, 1'b0);
      check_out();

      irq_raw = 8'h00;
      step(); step(); step();
      eoi(8'b1010_0001, 1'b0, 1'b0);
      eoi(8'b1010_0101, 1'b0, 1'b0);
      eoi(8'b1010_0111, 1'b0, 1'b0);
      push_exp("all_cleared", 8'h00, 8'h00, 8'h00);
      check_out();

      // edge mode with two pulses before EOI
      cfg_write(1'b1, 8'h01);
      for (int p = 0; p < 2; p++) begin
         irq_raw = 8'h01;
         step(); step();
         irq_raw = 8'h00;
         step(); step();
      end
      step(); step();
      push_exp("edge_overflow", 8'h01, 8'h01, OVF_ON ? 8'h01 : 8'h00);
      check_out();
      push_exp("edge_eoi_clear", 8'h00, 8'h00, 8'h00);
      eoi(8'b1010_0000, 1'b0, 1'b0);
      check_out();

      // build pending=55 then mask
      irq_raw = 8'h55;
      step(); step(); step();
      irq_raw = 8'h00;
      step(); step(); step();
      push_exp("pending_55", 8'h55, 8'h55, 8'h00);
      check_out();
      push_exp("mask_0f", 8'h50, 8'h55, 8'h00);
      cfg_write(1'b0, 8'h0F);
      check_out();
      push_exp("unmask", 8'h55, 8'h55, 8'h00);
      cfg_write(1'b0, 8'h00);
      check_out();

      // EOI filtering
      push_exp("eoi_bus_oe_ignored", 8'h55, 8'h55, 8'h00);
      eoi(8'b0101_1010, 1'b0, 1'b1);
      check_out();
      push_exp("eoi_no_strobe_ignored", 8'h55, 8'h55, 8'h00);
      eoi(8'b1010_0010, 1'b1, 1'b0);
      check_out();

      // new edge on line 2 coincides with its EOI
      cfg_write(1'b1, 8'h04);
      irq_raw = 8'h04;
      step(); step();
      push_exp("simultaneous_set_eoi", 8'h55, 8'h55, 8'h00);
      eoi(8'b1010_0010, 1'b0, 1'b0);
      check_out();

      if (sb_q.size() != 0) begin
         miscompares++;
         $error("FAIL scoreboard_leftover: got %0d entries, required 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
